// File: rtl/fork_join_pkg.sv
// fork_join_pkg: shared types and encodings for the fork/join sequencer.
// Holds the join-mode and FSM-state enumerations, the raw mode encodings
// seen on mode_i, the legacy state constants and a mode decode helper.
package fork_join_pkg;

   // Join policy applied to one launch.
   typedef enum logic [1:0] {
      JOIN_ALL  = 2'd0,
      JOIN_ANY  = 2'd1,
      JOIN_NONE = 2'd2
   } join_mode_e;

   // Sequencer FSM states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      JOINED = 2'd2
   } fj_state_e;

   // Raw encodings on mode_i. The reserved code behaves as join-all.
   localparam logic [1:0] MODE_ALL  = 2'd0;
   localparam logic [1:0] MODE_ANY  = 2'd1;
   localparam logic [1:0] MODE_NONE = 2'd2;
   localparam logic [1:0] MODE_RSVD = 2'd3;

   // State register encodings. These match fj_state_e so a debugger can
   // cast the register straight onto the enum.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_JOINED = 2'd2;

   // Map the raw mode bits onto the join policy. Reserved maps to ALL.
   function automatic join_mode_e decode_mode(input logic [1:0] raw);
      case (raw)
         MODE_ANY:  return JOIN_ANY;
         MODE_NONE: return JOIN_NONE;
         default:   return JOIN_ALL;
      endcase
   endfunction

endpackage

// File: rtl/fj_thread_timer.sv
// fj_thread_timer: one countdown "thread" of the fork/join sequencer.
//
// A load arms the thread with its delay. Each later cycle either counts
// down or, once the count has reached zero, completes the thread. This
// gives a done pulse delay+1 cycles after the load edge, so a delay of 0
// completes on the very next edge. The count never wraps, so every value
// of the counter is a usable delay.
//
// expire is combinational. It flags that the thread completes on the
// coming edge, which lets the parent evaluate join and kill on that same
// edge. A kill on the edge where the thread also expires is ignored:
// the thread completed rather than being aborted.
module fj_thread_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] delay,
   input  logic             kill,
   output logic             active,
   output logic             expire,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   assign expire = active && (cnt == '0);

   // Countdown, completion pulse and abort handling for one thread.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         active <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            cnt    <= delay;
            active <= 1'b1;
         end else if (active) begin
            if (expire) begin
               active <= 1'b0;
               done   <= 1'b1;
            end else if (kill) begin
               active <= 1'b0;
               cnt    <= '0;
            end else begin
               cnt <= cnt - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/fork_join_ctrl.sv
// fork_join_ctrl: fork/join sequencer.
//
// One start_i pulse (taken only while idle) launches N_CH countdown
// threads. The block reports each thread's completion on ch_done_o and
// fires a single join_o pulse per launch, according to the mode latched
// at launch:
//   ALL  - on the edge where the last thread completes
//   ANY  - on the edge where the first thread completes
//   NONE - on the edge after launch, whatever the delays
// first_idx_o records the lowest index among the first-finishing threads.
//
// Build option FORK_JOIN_KILL_EN: in ANY mode the join edge also aborts
// every thread still running, and killed_o reports which ones were
// aborted. Without the macro, leftover threads run to completion and
// killed_o is tied low.
//
// Handshake: start_i is a single-cycle request with no acknowledge. It is
// accepted only on an edge where the FSM is IDLE (busy_o low). A request
// on any other edge, including the edge that returns the block to IDLE,
// is dropped without effect.
module fork_join_ctrl
   import fork_join_pkg::*;
#(
   parameter  int N_CH  = 4,
   parameter  int CNT_W = 8,
   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [1:0]            mode_i,
   input  logic [N_CH*CNT_W-1:0] delay_i,
   output logic                  busy_o,
   output logic [N_CH-1:0]       ch_done_o,
   output logic                  join_o,
   output logic [IDX_W-1:0]      first_idx_o,
   output logic [N_CH-1:0]       killed_o
);

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   join_mode_e      mode_q;
   logic [N_CH-1:0] active;
   logic [N_CH-1:0] expire;
   logic [N_CH-1:0] remaining;
   logic [N_CH-1:0] kill_vec;
   logic [IDX_W-1:0] low_idx;
   logic            launch;
   logic            any_exp;
   logic            last_exp;
   logic            join_fire;
   logic            kill_fire;
   logic            first_seen;

   // A launch is only possible from IDLE.
   assign launch    = (state == ST_IDLE) && start_i;
   assign any_exp   = |expire;
   // Threads that are still running after the coming edge.
   assign remaining = active & ~expire;
   assign last_exp  = any_exp && (remaining == '0);

   // The thread array: all threads share the launch strobe and kill line.
   for (genvar i = 0; i < N_CH; i++) begin : g_thread
      fj_thread_timer #(
         .CNT_W (CNT_W)
      ) u_timer (
         .clk    (clk),
         .rst_n  (rst_n),
         .load   (launch),
         .delay  (delay_i[i*CNT_W +: CNT_W]),
         .kill   (kill_vec[i]),
         .active (active[i]),
         .expire (expire[i]),
         .done   (ch_done_o[i])
      );
   end

   // Join evaluation: only RUN can fire, so join_o fires once per launch.
   always_comb begin
      join_fire = 1'b0;
      if (state == ST_RUN) begin
         case (mode_q)
            JOIN_ANY:  join_fire = any_exp;
            JOIN_NONE: join_fire = 1'b1;
            default:   join_fire = last_exp;
         endcase
      end
   end

`ifdef FORK_JOIN_KILL_EN
   // Disable-fork: the ANY join edge aborts every thread still running.
   assign kill_fire = join_fire && (mode_q == JOIN_ANY);
`else
   assign kill_fire = 1'b0;
`endif

   // Threads that expire on the kill edge ignore the kill.
   assign kill_vec = {N_CH{kill_fire}};

   // Lowest index among the threads completing on the coming edge.
   always_comb begin
      low_idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (expire[i]) low_idx = IDX_W'(i);
      end
   end

   // Next-state logic. RUN waits for the join; JOINED waits for the last thread.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start_i) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (join_fire) begin
               if ((remaining == '0) || kill_fire) state_nxt = ST_IDLE;
               else                                state_nxt = ST_JOINED;
            end
         end
         ST_JOINED: begin
            if (last_exp) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM register, latched mode and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         mode_q      <= JOIN_ALL;
         busy_o      <= 1'b0;
         join_o      <= 1'b0;
         first_idx_o <= '0;
         first_seen  <= 1'b0;
      end else begin
         state  <= state_nxt;
         busy_o <= (state_nxt != ST_IDLE);
         join_o <= join_fire;
         if (launch) begin
            mode_q      <= decode_mode(mode_i);
            first_idx_o <= '0;
            first_seen  <= 1'b0;
         end else if (any_exp && !first_seen) begin
            first_idx_o <= low_idx;
            first_seen  <= 1'b1;
         end
      end
   end

`ifdef FORK_JOIN_KILL_EN
   // Aborted-thread record. It is cleared on launch and held until the next launch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         killed_o <= '0;
      end else if (launch) begin
         killed_o <= '0;
      end else if (kill_fire) begin
         killed_o <= remaining;
      end
   end
`else
   assign killed_o = '0;
`endif

endmodule
